alu_share_ctrl: RTL and testbench

Controller that time-shares one 32-bit combinational ALU (A, B, 3-bit opcode → result) between NUM_REQ requesters. It uses round-robin arbitration and valid/ready request handshakes. It registers the granted operands, drives the external ALU, captures the ALU result, and returns it on a tagged response channel. It sits between the requester clients and a single alu_32bit instance in the execution cluster.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_share_ctrl_if.sv | 38 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_share_ctrl.sv | 116 +++++++++++
 tb/tb_alu_share_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU sharing controller.
// Opcode constants follow the alu_32bit encoding.
package alu_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int OP_W_DEF    = 3;

  typedef logic [OP_W_DEF-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD = 3'b000;
  localparam alu_op_t ALU_OP_SUB = 3'b001;
  localparam alu_op_t ALU_OP_GT  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester, ALU and response signals of the ALU sharing controller.
// The slave modport is the controller's view; the master modport is the surrounding cluster's view.
interface alu_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high.
  // Once valid is raised, payload is held until the transfer completes.
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*OP_W-1:0]   req_op;

  logic [DATA_W-1:0]         alu_a;
  logic [DATA_W-1:0]         alu_b;
  logic [OP_W-1:0]           alu_opcode;
  logic [DATA_W-1:0]         alu_result;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_result
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opcode, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr_i, wrapping.
// Produces a one-hot grant, its index, and whether any request won.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o
);

  always_comb begin
    int idx;
    idx           = 0;
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!grant_valid_o && req_i[idx]) begin
        grant_valid_o = 1'b1;
        grant_o[idx]  = 1'b1;
        grant_idx_o   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU among NUM_REQ requesters: round-robin accept,
// one EXEC cycle on registered operands, then a tagged response held until taken.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_ctrl_if.slave   bus_io,
  output ctrl_state_t       state_o,
  output logic [ID_W-1:0]   rr_ptr_o
);

  ctrl_state_t         state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q;
  logic [OP_W-1:0]     op_code_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W-1:0]   rsp_result_q;

  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic                req_hs;
  logic                rsp_hs;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req_i         (bus_io.req_valid),
    .ptr_i         (rr_ptr_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  // In IDLE the granted requester always sees ready, so any grant is a handshake.
  assign req_hs = (state_q == IDLE) && grant_valid;
  assign rsp_hs = (state_q == RESP) && bus_io.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_io.req_ready = '0;
    bus_io.rsp_valid = 1'b0;
    case (state_q)
      IDLE:    bus_io.req_ready = grant;
      RESP:    bus_io.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // The served requester drops to lowest priority for the next arbitration.
  always_comb begin
    rr_ptr_d = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      if (req_hs) begin
        op_a_q    <= bus_io.req_a[int'(grant_idx)*DATA_W +: DATA_W];
        op_b_q    <= bus_io.req_b[int'(grant_idx)*DATA_W +: DATA_W];
        op_code_q <= bus_io.req_op[int'(grant_idx)*OP_W +: OP_W];
        id_q      <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= bus_io.alu_result;
        rsp_id_q     <= id_q;
      end
      if (rsp_hs) begin
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  // Operand registers only change on a handshake, so the ALU inputs hold otherwise.
  assign bus_io.alu_a      = op_a_q;
  assign bus_io.alu_b      = op_b_q;
  assign bus_io.alu_opcode = op_code_q;
  assign bus_io.rsp_id     = rsp_id_q;
  assign bus_io.rsp_result = rsp_result_q;

  assign state_o  = state_q;
  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl with a small behavioural ALU attached.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 3;
  localparam int ID_W    = 2;

  logic            clk;
  logic            rst;
  ctrl_state_t     state_dbg;
  logic [ID_W-1:0] rr_ptr_dbg;

  int errors;
  int checks;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] gnt_q[$];
  logic [DATA_W-1:0] rr_res[4];

  alu_share_ctrl_if #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .ID_W    (ID_W)
  ) bus ();

  alu_share_ctrl #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .OP_W    (OP_W),
    .ID_W    (ID_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_io   (bus),
    .state_o  (state_dbg),
    .rr_ptr_o (rr_ptr_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: unsupported opcodes return 0
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_opcode)
      ALU_OP_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_OP_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_OP_GT:  bus.alu_result = (bus.alu_a > bus.alu_b) ? 32'd1 : 32'd0;
      default:    bus.alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    bus.req_a[i*DATA_W +: DATA_W] = a;
    bus.req_b[i*DATA_W +: DATA_W] = b;
    bus.req_op[i*OP_W +: OP_W]    = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int grants;
    int resps;
    int last_cyc;
    logic [31:0] g;
    logic [31:0] e;

    errors = 0;
    checks = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    rst           = 1'b1;

    // reset values
    do_reset();
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    check("rst_rr_ptr", 32'(rr_ptr_dbg), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);

    // single GT op from requester 1
    set_req(1, 32'd7, 32'd3, ALU_OP_GT);
    bus.req_valid = 4'b0010;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = '0;
    #1;
    check("single_exec_state", 32'(state_dbg), 32'(EXEC));
    check("single_alu_op", 32'(bus.alu_opcode), 32'b010);
    check("single_alu_a", bus.alu_a, 32'd7);
    check("single_alu_b", bus.alu_b, 32'd3);
    check("single_exec_ready", 32'(bus.req_ready), 32'd0);
    check("single_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("single_rsp_id", 32'(bus.rsp_id), 32'd1);
    check("single_rsp_result", bus.rsp_result, 32'd1);
    bus.rsp_ready = 1'b1;
    tick();
    check("single_back_idle", 32'(state_dbg), 32'(IDLE));
    check("single_rr_ptr", 32'(rr_ptr_dbg), 32'd2);
    check("single_rsp_dropped", 32'(bus.rsp_valid), 32'd0);

    // round robin with all requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'h1000 * (i + 1), 32'(i + 1), ALU_OP_ADD);
    rr_res = '{32'h1001, 32'h2002, 32'h3003, 32'h4004};
    gnt_q  = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    exp_q  = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    grants   = 0;
    resps    = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 30 && resps < 5; cyc++) begin
      if (bus.req_ready != '0) begin
        g = (gnt_q.size() > 0) ? gnt_q.pop_front() : 32'd7;
        check("rr_grant", 32'(bus.req_ready), 32'd1 << g);
        if (grants > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        grants++;
      end
      if (bus.rsp_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd7;
        check("rr_rsp_id", 32'(bus.rsp_id), e);
        check("rr_rsp_result", bus.rsp_result, (e < 4) ? rr_res[e[1:0]] : 32'hDEAD);
        resps++;
        if (resps == 5) bus.req_valid = '0;
      end
      tick();
    end
    check("rr_resp_count", 32'(resps), 32'd5);
    check("rr_grant_count", 32'(grants), 32'd5);
    check("rr_ptr_after", 32'(rr_ptr_dbg), 32'd1);

    // backpressure and payload isolation, rr_ptr = 1
    bus.rsp_ready = 1'b0;
    set_req(2, 32'h10, 32'd5, ALU_OP_SUB);
    set_req(0, 32'h20, 32'd1, ALU_OP_ADD);
    bus.req_valid = 4'b0101;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_a[2*DATA_W +: DATA_W] = 32'hFF;
    #1;
    check("iso_alu_a", bus.alu_a, 32'h10);
    check("iso_alu_op", 32'(bus.alu_opcode), 32'b001);
    tick();
    check("bp_rsp_valid0", 32'(bus.rsp_valid), 32'd1);
    check("bp_rsp_id0", 32'(bus.rsp_id), 32'd2);
    check("iso_rsp_result", bus.rsp_result, 32'hB);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'd2);
      check("bp_rsp_result", bus.rsp_result, 32'hB);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_release_idle", 32'(state_dbg), 32'(IDLE));
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_rr_ptr", 32'(rr_ptr_dbg), 32'd3);
    check("bp_next_grant", 32'(bus.req_ready), 32'b0001);

    // wrap: ptr 3 with 1001 grants 3, then 0; unsupported opcode passes through
    set_req(3, 32'd9, 32'd4, 3'b111);
    bus.req_valid = 4'b1001;
    #1;
    check("wrap_grant3", 32'(bus.req_ready), 32'b1000);
    tick();
    check("wrap_alu_op", 32'(bus.alu_opcode), 32'b111);
    check("wrap_exec_ready", 32'(bus.req_ready), 32'd0);
    tick();
    check("wrap_rsp_id", 32'(bus.rsp_id), 32'd3);
    check("wrap_rsp_result", bus.rsp_result, 32'd0);
    tick();
    check("wrap_rr_ptr", 32'(rr_ptr_dbg), 32'd0);
    check("wrap_grant0", 32'(bus.req_ready), 32'b0001);

    // reset while a response is stalled
    tick();
    bus.rsp_ready = 1'b0;
    tick();
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("mid_rsp_result", bus.rsp_result, 32'h21);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    check("mid_rst_rr_ptr", 32'(rr_ptr_dbg), 32'd0);
    check("mid_rst_result", bus.rsp_result, 32'd0);
    check("mid_rst_alu_a", bus.alu_a, 32'd0);
    bus.req_valid = 4'b1111;
    #1;
    check("mid_rst_grant", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
